// File: rtl/vga_tile_scanner_if.sv
// -----------------------------------------------------------------------------
// vga_tile_scanner_if
//
// Output bundle of the VGA raster/tile scanner. The scanner drives it through
// the master modport; the downstream bit generator reads it through the slave
// modport.
//
// Signals:
//   act        - high while the current raster position is visible
//   hSync      - horizontal sync, active low
//   vSync      - vertical sync, active low
//   picNum     - row-major tile index (tileRow*TILES_X + tileCol)
//   xSubCount  - pixel column inside the 32x32 tile
//   ySubCount  - pixel row inside the 32x32 tile
//   frameStart - one-step pulse at raster position (0,0)
// -----------------------------------------------------------------------------
interface vga_tile_scanner_if;
    logic       act;
    logic       hSync;
    logic       vSync;
    logic [9:0] picNum;
    logic [4:0] xSubCount;
    logic [4:0] ySubCount;
    logic       frameStart;

    modport master (
        output act,
        output hSync,
        output vSync,
        output picNum,
        output xSubCount,
        output ySubCount,
        output frameStart
    );

    modport slave (
        input act,
        input hSync,
        input vSync,
        input picNum,
        input xSubCount,
        input ySubCount,
        input frameStart
    );
endinterface

// File: rtl/vga_tile_scanner.sv
// -----------------------------------------------------------------------------
// vga_tile_scanner
//
// Raster timing and tile-address generator for the 640x480@60 Hz VGA path.
// Walks an 800x525 raster and produces the active-video flag, both sync pulses,
// and the 32x32 tile coordinates used by the bit generator to address picture
// memory. Tile numbers are built incrementally (row base + column count), so
// no multiplier is needed.
//
// Ports:
//   clk    - system clock, all state on its rising edge
//   rst_n  - asynchronous, active-low reset
//   vga    - vga_tile_scanner_if.master: act, hSync, vSync, picNum,
//            xSubCount, ySubCount, frameStart (all registered, no skew)
//
// Compile-time option:
//   VGA_PIXDIV_EN - when defined, a 1-bit phase toggle makes a pixel step
//                   occur on every second clk (50 MHz clk, 25 MHz pixels).
//                   When undefined, every clk is a pixel step.
//
// Parameters describe the raster geometry; the defaults are 640x480@60.
// Tile size is fixed at 32x32, so H_VIS must be a multiple of 32.
// -----------------------------------------------------------------------------
module vga_tile_scanner #(
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int TILES_X = H_VIS / 32
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_tile_scanner_if.master vga
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [8:0] ROW_STEP = 9'(TILES_X);

    // ---------------------------------------------------------------------
    // Pixel-step enable
    // ---------------------------------------------------------------------
    logic step;

`ifdef VGA_PIXDIV_EN
    logic phase;

    // Phase resets to 0, so the first step lands on the second edge after
    // release; nothing else in the block moves while phase is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    assign step = phase;
`else
    assign step = 1'b1;
`endif

    // Registered state: raster position, tile row base and all outputs.
    logic [9:0] h_count_p1;
    logic [9:0] v_count_p1;
    logic [8:0] row_base_p1;
    logic       act_p1;
    logic       hsync_p1;
    logic       vsync_p1;
    logic [9:0] pic_num_p1;
    logic [4:0] x_sub_p1;
    logic [4:0] y_sub_p1;
    logic       frame_start_p1;

    // Next-step values, all derived from the new position.
    logic       h_wrap_p0;
    logic [9:0] h_next_p0;
    logic [9:0] v_next_p0;
    logic       vis_line_p0;
    logic       act_next_p0;
    logic [8:0] row_base_next_p0;
    logic [9:0] pic_next_p0;
    logic       hsync_next_p0;
    logic       vsync_next_p0;
    logic [4:0] x_sub_next_p0;
    logic [4:0] y_sub_next_p0;
    logic       frame_start_next_p0;

    // ---------------------------------------------------------------------
    // Stage p0: next raster position and the outputs it implies
    // ---------------------------------------------------------------------
    always_comb begin
        h_wrap_p0           = (h_count_p1 == H_LAST);
        h_next_p0           = h_count_p1 + 10'd1;
        v_next_p0           = v_count_p1;
        vis_line_p0         = 1'b0;
        act_next_p0         = 1'b0;
        row_base_next_p0    = row_base_p1;
        pic_next_p0         = pic_num_p1;
        hsync_next_p0       = 1'b1;
        vsync_next_p0       = 1'b1;
        x_sub_next_p0       = 5'd0;
        y_sub_next_p0       = 5'd0;
        frame_start_next_p0 = 1'b0;

        if (h_wrap_p0) begin
            h_next_p0 = 10'd0;
            if (v_count_p1 == V_LAST) begin
                v_next_p0 = 10'd0;
            end else begin
                v_next_p0 = v_count_p1 + 10'd1;
            end
        end

        vis_line_p0 = (v_next_p0 < V_VIS_C);
        act_next_p0 = (h_next_p0 < H_VIS_C) && vis_line_p0;

        // Row base moves only at a line start. Frame wrap wins over the
        // tile-row increment so (0,0) always starts from tile 0. Lines past
        // the visible area do not advance it, which caps it at the last
        // visible tile row.
        if (h_wrap_p0) begin
            if (v_next_p0 == 10'd0) begin
                row_base_next_p0 = 9'd0;
            end else if ((v_next_p0[4:0] == 5'd0) && vis_line_p0) begin
                row_base_next_p0 = row_base_p1 + ROW_STEP;
            end
        end

        // Blanking forces tile 0, which also covers a column boundary that
        // coincides with the end of the visible line.
        if (!act_next_p0) begin
            pic_next_p0 = 10'd0;
        end else if (h_wrap_p0) begin
            pic_next_p0 = {1'b0, row_base_next_p0};
        end else if (h_next_p0[4:0] == 5'd0) begin
            pic_next_p0 = pic_num_p1 + 10'd1;
        end

        hsync_next_p0 = !((h_next_p0 >= HS_BEG) && (h_next_p0 < HS_END));
        vsync_next_p0 = !((v_next_p0 >= VS_BEG) && (v_next_p0 < VS_END));

        if (act_next_p0) begin
            x_sub_next_p0 = h_next_p0[4:0];
        end

        // Tile row holds through horizontal blanking of a visible line.
        if (vis_line_p0) begin
            y_sub_next_p0 = v_next_p0[4:0];
        end

        frame_start_next_p0 = (h_next_p0 == 10'd0) && (v_next_p0 == 10'd0);
    end

    // ---------------------------------------------------------------------
    // Stage p1: registered position and outputs, updated once per step
    // ---------------------------------------------------------------------
    // Reset parks the raster on the last blanking position so the first
    // step after release lands exactly on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count_p1     <= H_LAST;
            v_count_p1     <= V_LAST;
            row_base_p1    <= 9'd0;
            act_p1         <= 1'b0;
            hsync_p1       <= 1'b1;
            vsync_p1       <= 1'b1;
            pic_num_p1     <= 10'd0;
            x_sub_p1       <= 5'd0;
            y_sub_p1       <= 5'd0;
            frame_start_p1 <= 1'b0;
        end else if (step) begin
            h_count_p1     <= h_next_p0;
            v_count_p1     <= v_next_p0;
            row_base_p1    <= row_base_next_p0;
            act_p1         <= act_next_p0;
            hsync_p1       <= hsync_next_p0;
            vsync_p1       <= vsync_next_p0;
            pic_num_p1     <= pic_next_p0;
            x_sub_p1       <= x_sub_next_p0;
            y_sub_p1       <= y_sub_next_p0;
            frame_start_p1 <= frame_start_next_p0;
        end
    end

    assign vga.act        = act_p1;
    assign vga.hSync      = hsync_p1;
    assign vga.vSync      = vsync_p1;
    assign vga.picNum     = pic_num_p1;
    assign vga.xSubCount  = x_sub_p1;
    assign vga.ySubCount  = y_sub_p1;
    assign vga.frameStart = frame_start_p1;

endmodule

// File: tb/tb_vga_tile_scanner.sv
// -----------------------------------------------------------------------------
// tb_vga_tile_scanner
//
// Bench for vga_tile_scanner. Two instances share clock and reset: one with
// the standard 640x480 geometry, one with a reduced geometry (64x96 visible,
// 80x102 total) so whole frames fit in a short run. A position-level model
// predicts every output from the raster position with plain arithmetic.
// Builds with or without VGA_PIXDIV_EN.
// -----------------------------------------------------------------------------
module tb_vga_tile_scanner;

`ifdef VGA_PIXDIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // Standard geometry
    localparam int B_HVIS = 640, B_HFP = 16, B_HSY = 96, B_HBP = 48;
    localparam int B_VVIS = 480, B_VFP = 10, B_VSY = 2,  B_VBP = 33;
    localparam int B_HT = B_HVIS + B_HFP + B_HSY + B_HBP;
    localparam int B_VT = B_VVIS + B_VFP + B_VSY + B_VBP;
    // Reduced geometry
    localparam int S_HVIS = 64, S_HFP = 4, S_HSY = 8, S_HBP = 4;
    localparam int S_VVIS = 96, S_VFP = 2, S_VSY = 2, S_VBP = 2;
    localparam int S_HT = S_HVIS + S_HFP + S_HSY + S_HBP;
    localparam int S_VT = S_VVIS + S_VFP + S_VSY + S_VBP;

    // {act, hSync, vSync, picNum[9:0], xSub[4:0], ySub[4:0], frameStart}
    localparam logic [23:0] RST_VEC   = {1'b0, 1'b1, 1'b1, 10'd0, 5'd0, 5'd0, 1'b0};
    localparam logic [23:0] FIRST_VEC = {1'b1, 1'b1, 1'b1, 10'd0, 5'd0, 5'd0, 1'b1};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    vga_tile_scanner_if bus_b ();
    vga_tile_scanner_if bus_s ();

    vga_tile_scanner dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (bus_b)
    );

    vga_tile_scanner #(
        .H_VIS(S_HVIS), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
        .V_VIS(S_VVIS), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (bus_s)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: current raster position of each instance.
    int   bh = B_HT - 1, bv = B_VT - 1;
    int   sh = S_HT - 1, sv = S_VT - 1;
    logic ph = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bh <= B_HT - 1; bv <= B_VT - 1;
            sh <= S_HT - 1; sv <= S_VT - 1;
            ph <= 1'b0;
        end else begin
`ifdef VGA_PIXDIV_EN
            if (ph) begin
`else
            begin
`endif
                bh <= (bh == B_HT - 1) ? 0 : bh + 1;
                bv <= (bh == B_HT - 1) ? (bv + 1) % B_VT : bv;
                sh <= (sh == S_HT - 1) ? 0 : sh + 1;
                sv <= (sh == S_HT - 1) ? (sv + 1) % S_VT : sv;
            end
            ph <= !ph;
        end
    end

    function automatic logic [23:0] expect_out(int h, int v, int hvis, int hfp,
                                               int hsy, int vvis, int vfp, int vsy);
        logic a, hs, vs, fs;
        logic [9:0] pic;
        logic [4:0] x, y;
        a   = (h < hvis) && (v < vvis);
        hs  = !((h >= hvis + hfp) && (h < hvis + hfp + hsy));
        vs  = !((v >= vvis + vfp) && (v < vvis + vfp + vsy));
        pic = a ? 10'((v / 32) * (hvis / 32) + h / 32) : 10'd0;
        x   = a ? 5'(h % 32) : 5'd0;
        y   = (v < vvis) ? 5'(v % 32) : 5'd0;
        fs  = (h == 0) && (v == 0);
        return {a, hs, vs, pic, x, y, fs};
    endfunction

    function automatic logic [23:0] obs_b();
        return {bus_b.act, bus_b.hSync, bus_b.vSync, bus_b.picNum,
                bus_b.xSubCount, bus_b.ySubCount, bus_b.frameStart};
    endfunction

    function automatic logic [23:0] obs_s();
        return {bus_s.act, bus_s.hSync, bus_s.vSync, bus_s.picNum,
                bus_s.xSubCount, bus_s.ySubCount, bus_s.frameStart};
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_b() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_big got=%h want=%h", obs_b(), RST_VEC);
        end
        n_cmp++;
        if (obs_s() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_small got=%h want=%h", obs_s(), RST_VEC);
        end
    endtask

    task automatic test_release();
        rst_n = 1'b1;
`ifdef VGA_PIXDIV_EN
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_b() !== RST_VEC) begin
            n_bad++;
            $display("FAIL release_hold_edge1 got=%h want=%h", obs_b(), RST_VEC);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_b() !== FIRST_VEC) begin
            n_bad++;
            $display("FAIL release_first_big got=%h want=%h", obs_b(), FIRST_VEC);
        end
        n_cmp++;
        if (obs_s() !== FIRST_VEC) begin
            n_bad++;
            $display("FAIL release_first_small got=%h want=%h", obs_s(), FIRST_VEC);
        end
    endtask

    task automatic test_scan();
        int   cyc = 0;
        int   hs_low = 0, hs_first = -1;
        int   fs_seen = 0, sm_start = 0, sm_period = -1, vs_low = 0;
        logic fs_prev = 1'b0;
        logic [23:0] e;
        while (!(bv == 32 && bh == 40) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            e = expect_out(bh, bv, B_HVIS, B_HFP, B_HSY, B_VVIS, B_VFP, B_VSY);
            n_cmp++;
            if (obs_b() !== e) begin
                n_bad++;
                $display("FAIL scan_big h=%0d v=%0d got=%h want=%h", bh, bv, obs_b(), e);
            end
            e = expect_out(sh, sv, S_HVIS, S_HFP, S_HSY, S_VVIS, S_VFP, S_VSY);
            n_cmp++;
            if (obs_s() !== e) begin
                n_bad++;
                $display("FAIL scan_small h=%0d v=%0d got=%h want=%h", sh, sv, obs_s(), e);
            end
            // Named boundary points, standard geometry
            if (bh == 31 && bv == 0) begin
                n_cmp++;
                if (bus_b.xSubCount !== 5'd31 || bus_b.picNum !== 10'd0) begin
                    n_bad++;
                    $display("FAIL tile_edge31 x=%0d pic=%0d want x=31 pic=0", bus_b.xSubCount, bus_b.picNum);
                end
            end
            if (bh == 32 && bv == 0) begin
                n_cmp++;
                if (bus_b.xSubCount !== 5'd0 || bus_b.picNum !== 10'd1) begin
                    n_bad++;
                    $display("FAIL tile_edge32 x=%0d pic=%0d want x=0 pic=1", bus_b.xSubCount, bus_b.picNum);
                end
            end
            if (bh == 640 && bv == 0) begin
                n_cmp++;
                if (bus_b.act !== 1'b0 || bus_b.picNum !== 10'd0) begin
                    n_bad++;
                    $display("FAIL line_end act=%b pic=%0d want act=0 pic=0", bus_b.act, bus_b.picNum);
                end
            end
            if (bh == 0 && bv == 32) begin
                n_cmp++;
                if (bus_b.picNum !== 10'd20 || bus_b.ySubCount !== 5'd0 || bus_b.act !== 1'b1) begin
                    n_bad++;
                    $display("FAIL row32_start pic=%0d y=%0d act=%b want pic=20 y=0 act=1",
                             bus_b.picNum, bus_b.ySubCount, bus_b.act);
                end
            end
            // Frame extremes, reduced geometry
            if (sh == S_HVIS - 1 && sv == S_VVIS - 1) begin
                n_cmp++;
                if (bus_s.picNum !== 10'd5 || bus_s.xSubCount !== 5'd31 || bus_s.ySubCount !== 5'd31) begin
                    n_bad++;
                    $display("FAIL last_pixel pic=%0d x=%0d y=%0d want 5/31/31",
                             bus_s.picNum, bus_s.xSubCount, bus_s.ySubCount);
                end
            end
            if (sh == S_HVIS && sv == S_VVIS - 1) begin
                n_cmp++;
                if (bus_s.act !== 1'b0) begin
                    n_bad++;
                    $display("FAIL after_last act=%b want 0", bus_s.act);
                end
            end
            if (sh == 0 && sv == 0) begin
                n_cmp++;
                if (bus_s.frameStart !== 1'b1 || bus_s.picNum !== 10'd0) begin
                    n_bad++;
                    $display("FAIL frame_wrap fs=%b pic=%0d want fs=1 pic=0", bus_s.frameStart, bus_s.picNum);
                end
            end
            // Sync window and frame period measurements from DUT outputs
            if (bv == 0 && bus_b.hSync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = bh;
            end
            if (bus_s.frameStart === 1'b1 && !fs_prev) begin
                fs_seen++;
                if (fs_seen == 1) sm_start = cyc;
                else if (fs_seen == 2) sm_period = cyc - sm_start;
            end
            if (fs_seen == 1 && bus_s.vSync === 1'b0) vs_low++;
            fs_prev = bus_s.frameStart;
        end
        n_cmp++;
        if (cyc >= 60000) begin
            n_bad++;
            $display("FAIL scan_timeout cycles=%0d want <60000", cyc);
        end
        n_cmp++;
        if (hs_low != B_HSY * DIV || hs_first != B_HVIS + B_HFP) begin
            n_bad++;
            $display("FAIL hsync_window low=%0d start=%0d want low=%0d start=%0d",
                     hs_low, hs_first, B_HSY * DIV, B_HVIS + B_HFP);
        end
        n_cmp++;
        if (vs_low != S_VSY * S_HT * DIV) begin
            n_bad++;
            $display("FAIL vsync_window low=%0d want %0d", vs_low, S_VSY * S_HT * DIV);
        end
        n_cmp++;
        if (sm_period != S_HT * S_VT * DIV) begin
            n_bad++;
            $display("FAIL frame_period got=%0d want %0d", sm_period, S_HT * S_VT * DIV);
        end
    endtask

    task automatic test_reset_mid_line();
        for (int k = 0; k < 3; k++) begin
            int target = int'($urandom_range(290, 310));
            int wait_c = 0;
            int run_c;
            logic [23:0] e;
            while (bh != target && wait_c < 2000) begin
                @(negedge clk);
                wait_c++;
            end
            n_cmp++;
            if (wait_c >= 2000) begin
                n_bad++;
                $display("FAIL midreset_wait h=%0d want %0d", bh, target);
            end
            // Assert between edges; outputs must clear before any clock edge.
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            #1;
            n_cmp++;
            if (obs_b() !== RST_VEC || obs_s() !== RST_VEC) begin
                n_bad++;
                $display("FAIL midreset_async big=%h small=%h want %h", obs_b(), obs_s(), RST_VEC);
            end
            repeat ($urandom_range(1, 5)) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (DIV) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (obs_b() !== FIRST_VEC || obs_s() !== FIRST_VEC) begin
                n_bad++;
                $display("FAIL midreset_restart big=%h small=%h want %h", obs_b(), obs_s(), FIRST_VEC);
            end
            run_c = int'($urandom_range(300, 900));
            for (int c = 0; c < run_c; c++) begin
                @(negedge clk);
                e = expect_out(bh, bv, B_HVIS, B_HFP, B_HSY, B_VVIS, B_VFP, B_VSY);
                n_cmp++;
                if (obs_b() !== e) begin
                    n_bad++;
                    $display("FAIL midreset_big h=%0d v=%0d got=%h want=%h", bh, bv, obs_b(), e);
                end
                e = expect_out(sh, sv, S_HVIS, S_HFP, S_HSY, S_VVIS, S_VFP, S_VSY);
                n_cmp++;
                if (obs_s() !== e) begin
                    n_bad++;
                    $display("FAIL midreset_small h=%0d v=%0d got=%h want=%h", sh, sv, obs_s(), e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_scan();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_tile_scanner.md
# vga_tile_scanner

Raster timing and tile-address generator for the 640x480@60 Hz VGA path. It sits directly upstream of the VGA bit generator. It produces the active-video flag, sync pulses and the tile coordinates (`picNum`, `xSubCount`, `ySubCount`) that the bit generator uses to form picture-memory fetch addresses. All tile arithmetic is done incrementally with counters; the block contains no multipliers.

## Interface
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixel steps)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch; line total is 800
- `V_VIS`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch; frame total is 525
- `TILES_X`, 20, tiles per line (`H_VIS`/32); tile size is fixed at 32x32
- `clk`  in  1  system clock; one clock, and all state is on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `act`  out  1  high while the current position is visible
- `hSync`  out  1  horizontal sync, active low
- `vSync`  out  1  vertical sync, active low
- `picNum`  out  10  tile index, row-major: tileRow*`TILES_X` + tileCol
- `xSubCount`  out  5  column within the tile, 0..31
- `ySubCount`  out  5  row within the tile, 0..31
- `frameStart`  out  1  one-step pulse at position (0,0)

## Operation
- **Pixel step.** A pixel step is every `clk`, or every second `clk` when the divider is compiled in (see Configuration). Nothing changes between steps.
- **Position counters.** `hCount` (10b) counts 0..799 and wraps to 0. `vCount` (10b) advances when `hCount` wraps, counts 0..524 and wraps to 0.
- **Reset position.** Reset loads `hCount`=799 and `vCount`=524, the last blanking position. The first step after `rst_n` rises therefore lands on (0,0).
- **Registered outputs.** Every output is registered and is updated on each step from the *new* position.
- **act:** 1 when `hCount`<640 and `vCount`<480.
- **hSync:** 0 when 656 ≤ `hCount` < 752.
- **vSync:** 0 when 490 ≤ `vCount` < 492. `vSync` is evaluated per step, so it changes coincident with `hCount`=0.
- **xSubCount:** `hCount[4:0]` while `act`=1, otherwise 0.
- **ySubCount:** `vCount[4:0]` while `vCount`<480, otherwise 0. It holds its value through horizontal blanking.
- **rowBase register (9b).** Reset to 0 at `vCount`=0. Incremented by `TILES_X` when a line starts whose `vCount[4:0]`=0 and `vCount`≠0. Maximum value is 280.
- **picNum.**
  - Loaded with `rowBase` at `hCount`=0.
  - Incremented by 1 when `hCount[4:0]` steps from 31 to 0 within the visible region.
  - Forced to 0 when `act`=0.
  - Maximum value is 299, so it never exceeds 10 bits.
- **frameStart:** 1 for exactly one step when the position is (0,0), otherwise 0.
- **Simultaneous events.**
  - The line wrap and frame wrap at (799,524)→(0,0) occur in the same step. `rowBase` and `picNum` both take 0, not 20.
  - A tile-column boundary coinciding with `hCount`=640 yields `picNum`=0 with `act`=0.
- **Reset mid-frame.** Assertion of `rst_n` immediately forces every output to its reset value and the counters to (799,524), regardless of the divider phase. Release restarts a clean frame.

## Timing
- **Output reset values:** `act`=0, `hSync`=1, `vSync`=1, `picNum`=0, `xSubCount`=0, `ySubCount`=0, `frameStart`=0.
- **Latency:** the first visible step occurs 1 step after reset release.
- **Alignment:** all outputs change on the same `clk` edge, with no skew between them. The downstream memory fetch adds 1 `clk` of latency; delaying the syncs to match is the downstream block's responsibility.
- **Line and frame length:** a line is 800 steps and a frame is 420000 steps. `act` is high for 640 consecutive steps per visible line.

## Configuration
- **`VGA_PIXDIV_EN`, defined:**
  - An internal 1-bit phase toggle makes a pixel step occur on every second `clk`, for a 50 MHz `clk` and 25 MHz pixel rate.
  - The toggle resets to 0; the first step happens on the second `clk` edge after release.
  - Each output value is held for 2 `clk`, and a frame is 840000 `clk`.
- **Not defined:** every `clk` is a step; no divider logic is present.

## Test plan
- **Reset release, no divider:** assert `rst_n`=0 → outputs at reset values. Release → on the first edge `act`=1, `frameStart`=1, `picNum`=0, `xSubCount`=0, `ySubCount`=0.
- **Tile and row boundaries:**
  - Step through line 0: at `hCount`=31, `xSubCount`=31 and `picNum`=0; at 32, `xSubCount`=0 and `picNum`=1.
  - At `hCount`=640, `act`=0 and `picNum`=0.
  - Line 32 starts with `picNum`=20 and `ySubCount`=0.
- **Frame extremes:**
  - Position (639,479) → `picNum`=299, `xSubCount`=31, `ySubCount`=31.
  - The next step gives `act`=0.
  - After the wrap to (0,0), `picNum`=0 and `frameStart`=1.
- **Sync windows:**
  - `hSync` is low for exactly 96 steps starting at `hCount`=656.
  - `vSync` is low for exactly 1600 steps (lines 490–491).
  - Frame period is 420000 clk.
- **`VGA_PIXDIV_EN` defined:**
  - Outputs change only every 2 clk.
  - The first visible output appears on the 2nd edge after release.
  - Frame period is 840000 clk.
- **Reset mid-line:** assert `rst_n` at `hCount`≈300, `vCount`=100 → outputs return to reset values asynchronously. After release, the sequence restarts at (0,0) with `frameStart`=1.
